// File: rtl/sbox_share_arbiter.sv
// Round-robin arbiter sharing one pipelined S-box between the key-schedule and
// data-state requesters; owner tags route each result back to its requester.
module sbox_share_arbiter #(
  parameter int unsigned SBOX_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       ks_req_valid,
  input  logic [7:0] ks_req_byte,
  input  logic       ks_req_inv,
  output logic       ks_req_ready,
  input  logic       ds_req_valid,
  input  logic [7:0] ds_req_byte,
  input  logic       ds_req_inv,
  output logic       ds_req_ready,
  output logic       sbox_in_valid,
  output logic [7:0] sbox_in,
  output logic       sbox_inv,
  input  logic [7:0] sbox_out,
  output logic       ks_rsp_valid,
  output logic [7:0] ks_rsp_byte,
  output logic       ds_rsp_valid,
  output logic [7:0] ds_rsp_byte,
  output logic       busy
);

  localparam int unsigned NSTG    = SBOX_LAT + 1;
  localparam int unsigned CNT_MAX = SBOX_LAT + 2;
  localparam int unsigned CNT_W   = $clog2(SBOX_LAT + 3);

  // Encoded so that the reset value (0) means "ds granted last"
  localparam logic GRANT_DS = 1'b0;
  localparam logic GRANT_KS = 1'b1;

  logic             last_grant_q, last_grant_d;
  logic             sbox_in_valid_q, sbox_in_valid_d;
  logic [7:0]       sbox_in_q, sbox_in_d;
  logic             sbox_inv_q, sbox_inv_d;
  logic [NSTG-1:0]  tag_vld_q, tag_vld_d;
  logic [NSTG-1:0]  tag_own_q, tag_own_d;
  logic             ks_rsp_valid_q, ks_rsp_valid_d;
  logic [7:0]       ks_rsp_byte_q, ks_rsp_byte_d;
  logic             ds_rsp_valid_q, ds_rsp_valid_d;
  logic [7:0]       ds_rsp_byte_q, ds_rsp_byte_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ks_acc, ds_acc, acc, rsp_done, rsp_out;

  // Combinational grant: a lone requester wins, contention alternates
  always_comb begin
    ks_req_ready = ~flush & ks_req_valid & (~ds_req_valid | (last_grant_q == GRANT_DS));
    ds_req_ready = ~flush & ds_req_valid & (~ks_req_valid | (last_grant_q == GRANT_KS));
    ks_acc       = ks_req_valid & ks_req_ready;
    ds_acc       = ds_req_valid & ds_req_ready;
    acc          = ks_acc | ds_acc;
  end

  always_comb begin
    last_grant_d    = last_grant_q;
    sbox_in_valid_d = acc;
    sbox_in_d       = sbox_in_q;
    sbox_inv_d      = sbox_inv_q;
    tag_vld_d       = {tag_vld_q[NSTG-2:0], acc};
    tag_own_d       = {tag_own_q[NSTG-2:0], ds_acc};
    ks_rsp_byte_d   = ks_rsp_byte_q;
    ds_rsp_byte_d   = ds_rsp_byte_q;
    cnt_d           = cnt_q;

    if (ks_acc) begin
      last_grant_d = GRANT_KS;
      sbox_in_d    = ks_req_byte;
      sbox_inv_d   = ks_req_inv;
    end else if (ds_acc) begin
      last_grant_d = GRANT_DS;
      sbox_in_d    = ds_req_byte;
      sbox_inv_d   = ds_req_inv;
    end

    // Final tag stage lines up with the S-box result for that beat
    rsp_done       = tag_vld_q[NSTG-1] & ~flush;
    ks_rsp_valid_d = rsp_done & ~tag_own_q[NSTG-1];
    ds_rsp_valid_d = rsp_done &  tag_own_q[NSTG-1];
    if (ks_rsp_valid_d) ks_rsp_byte_d = sbox_out;
    if (ds_rsp_valid_d) ds_rsp_byte_d = sbox_out;

    // A beat stays counted until its response pulse has been presented
    rsp_out = ks_rsp_valid_q | ds_rsp_valid_q;
    if (acc && !rsp_out) begin
      if (cnt_q != CNT_W'(CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
    end else if (!acc && rsp_out) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end

    if (flush) begin
      tag_vld_d       = '0;
      sbox_in_valid_d = 1'b0;
      cnt_d           = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q    <= GRANT_DS;
      sbox_in_valid_q <= 1'b0;
      sbox_in_q       <= '0;
      sbox_inv_q      <= 1'b0;
      tag_vld_q       <= '0;
      tag_own_q       <= '0;
      ks_rsp_valid_q  <= 1'b0;
      ks_rsp_byte_q   <= '0;
      ds_rsp_valid_q  <= 1'b0;
      ds_rsp_byte_q   <= '0;
      cnt_q           <= '0;
    end else begin
      last_grant_q    <= last_grant_d;
      sbox_in_valid_q <= sbox_in_valid_d;
      sbox_in_q       <= sbox_in_d;
      sbox_inv_q      <= sbox_inv_d;
      tag_vld_q       <= tag_vld_d;
      tag_own_q       <= tag_own_d;
      ks_rsp_valid_q  <= ks_rsp_valid_d;
      ks_rsp_byte_q   <= ks_rsp_byte_d;
      ds_rsp_valid_q  <= ds_rsp_valid_d;
      ds_rsp_byte_q   <= ds_rsp_byte_d;
      cnt_q           <= cnt_d;
    end
  end

  assign sbox_in_valid = sbox_in_valid_q;
  assign sbox_in       = sbox_in_q;
  assign sbox_inv      = sbox_inv_q;
  assign ks_rsp_valid  = ks_rsp_valid_q;
  assign ks_rsp_byte   = ks_rsp_byte_q;
  assign ds_rsp_valid  = ds_rsp_valid_q;
  assign ds_rsp_byte   = ds_rsp_byte_q;
  assign busy          = (cnt_q != '0);

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Scoreboard bench for sbox_share_arbiter with a behavioural pipelined AES S-box.
module tb_sbox_share_arbiter;

  localparam int unsigned LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       ks_req_valid, ks_req_inv, ks_req_ready;
  logic [7:0] ks_req_byte;
  logic       ds_req_valid, ds_req_inv, ds_req_ready;
  logic [7:0] ds_req_byte;
  logic       sbox_in_valid, sbox_inv;
  logic [7:0] sbox_in, sbox_out;
  logic       ks_rsp_valid, ds_rsp_valid, busy;
  logic [7:0] ks_rsp_byte, ds_rsp_byte;

  sbox_share_arbiter #(.SBOX_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ks_req_valid(ks_req_valid), .ks_req_byte(ks_req_byte), .ks_req_inv(ks_req_inv),
    .ks_req_ready(ks_req_ready),
    .ds_req_valid(ds_req_valid), .ds_req_byte(ds_req_byte), .ds_req_inv(ds_req_inv),
    .ds_req_ready(ds_req_ready),
    .sbox_in_valid(sbox_in_valid), .sbox_in(sbox_in), .sbox_inv(sbox_inv),
    .sbox_out(sbox_out),
    .ks_rsp_valid(ks_rsp_valid), .ks_rsp_byte(ks_rsp_byte),
    .ds_rsp_valid(ds_rsp_valid), .ds_rsp_byte(ds_rsp_byte),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // GF(2^8) arithmetic for the external S-box model
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gf_mul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] s = gf_inv(x);
    return s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_i(input logic [7:0] x);
    return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  logic [7:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= sbox_inv ? sbox_i(sbox_in) : sbox_f(sbox_in);
    for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign sbox_out = pipe[LAT-1];

  typedef struct {
    logic [7:0] b;
    int         cyc;
  } exp_t;

  exp_t ks_q[$];
  exp_t ds_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic push_ks(input logic [7:0] b, input int c);
    exp_t e;
    e.b = b; e.cyc = c;
    ks_q.push_back(e);
  endtask

  task automatic push_ds(input logic [7:0] b, input int c);
    exp_t e;
    e.b = b; e.cyc = c;
    ds_q.push_back(e);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b required %0b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h required %02h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the queued byte and cycle
  always @(negedge clk) begin
    exp_t e;
    if (ks_rsp_valid) begin
      checks++;
      if (ks_q.size() == 0) begin
        failures++;
        $display("FAIL ks_rsp_unexpected: got %02h at cyc %0d, required no pulse", ks_rsp_byte, cyc);
      end else begin
        e = ks_q.pop_front();
        if (ks_rsp_byte !== e.b || cyc != e.cyc) begin
          failures++;
          $display("FAIL ks_rsp: got %02h at cyc %0d required %02h at cyc %0d", ks_rsp_byte, cyc, e.b, e.cyc);
        end
      end
    end
    if (ds_rsp_valid) begin
      checks++;
      if (ds_q.size() == 0) begin
        failures++;
        $display("FAIL ds_rsp_unexpected: got %02h at cyc %0d, required no pulse", ds_rsp_byte, cyc);
      end else begin
        e = ds_q.pop_front();
        if (ds_rsp_byte !== e.b || cyc != e.cyc) begin
          failures++;
          $display("FAIL ds_rsp: got %02h at cyc %0d required %02h at cyc %0d", ds_rsp_byte, cyc, e.b, e.cyc);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [7:0] fwd_row0 [16] = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
                                8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76};
  logic [7:0] kb [2]   = '{8'h53, 8'h00};
  logic       kinv [2] = '{1'b0, 1'b0};
  logic [7:0] db [2]   = '{8'h63, 8'h01};
  logic       dinv [2] = '{1'b1, 1'b0};
  logic       gks [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int t0, ki, di;
    rst_n = 1'b0; flush = 1'b0;
    ks_req_valid = 1'b0; ks_req_byte = 8'h00; ks_req_inv = 1'b0;
    ds_req_valid = 1'b0; ds_req_byte = 8'h00; ds_req_inv = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_sbox_in_valid", sbox_in_valid, 1'b0);
    chk8("rst_sbox_in", sbox_in, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ks_rsp_valid", ks_rsp_valid, 1'b0);
    chk8("rst_ds_rsp_byte", ds_rsp_byte, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Single ks forward beat: 0x00 -> 0x63 after SBOX_LAT+2 cycles
    t0 = cyc;
    ks_req_valid = 1'b1; ks_req_byte = 8'h00; ks_req_inv = 1'b0;
    push_ks(8'h63, t0 + 6);
    #1;
    chk1("single_ks_ready", ks_req_ready, 1'b1);
    chk1("single_ds_ready", ds_req_ready, 1'b0);
    @(negedge clk);
    ks_req_valid = 1'b0;
    chk1("single_issue_valid", sbox_in_valid, 1'b1);
    chk8("single_issue_byte", sbox_in, 8'h00);
    chk1("single_issue_inv", sbox_inv, 1'b0);
    chk1("single_busy", busy, 1'b1);
    @(negedge clk);
    chk1("single_idle_valid", sbox_in_valid, 1'b0);
    chk8("single_idle_hold", sbox_in, 8'h00);
    repeat (8) @(negedge clk);

    // Round-robin contention from reset
    do_reset();
    t0 = cyc; ki = 0; di = 0;
    push_ks(8'hed, t0 + 6); push_ds(8'h00, t0 + 7);
    push_ks(8'h63, t0 + 8); push_ds(8'h7c, t0 + 9);
    for (int k = 0; k < 4; k++) begin
      ks_req_valid = (ki < 2); ds_req_valid = (di < 2);
      if (ki < 2) begin ks_req_byte = kb[ki]; ks_req_inv = kinv[ki]; end
      if (di < 2) begin ds_req_byte = db[di]; ds_req_inv = dinv[di]; end
      #1;
      chk1($sformatf("rr_ks_ready%0d", k), ks_req_ready, gks[k]);
      chk1($sformatf("rr_ds_ready%0d", k), ds_req_ready, ~gks[k]);
      if (ks_req_ready) ki++;
      if (ds_req_ready) di++;
      @(negedge clk);
    end
    ks_req_valid = 1'b0; ds_req_valid = 1'b0;
    repeat (8) @(negedge clk);

    // ds streams 16 back-to-back bytes
    t0 = cyc;
    for (int i = 0; i < 16; i++) push_ds(fwd_row0[i], t0 + 6 + i);
    for (int k = 0; k < 24; k++) begin
      ds_req_valid = (k < 16); ds_req_byte = 8'(k); ds_req_inv = 1'b0;
      chk1($sformatf("stream_issue%0d", k), sbox_in_valid, 1'((k >= 1) && (k <= 16)));
      if (k >= 1 && k <= 16) chk8($sformatf("stream_byte%0d", k), sbox_in, 8'(k - 1));
      if (k == 21) chk1("stream_busy_last", busy, 1'b1);
      if (k == 22) chk1("stream_busy_fall", busy, 1'b0);
      #1;
      if (k < 16) chk1($sformatf("stream_ready%0d", k), ds_req_ready, 1'b1);
      @(negedge clk);
    end
    ds_req_valid = 1'b0;

    // Three ks beats in flight, then a one-cycle flush
    t0 = cyc;
    for (int k = 0; k < 14; k++) begin
      ks_req_valid = (k <= 3) || (k == 5);
      ds_req_valid = (k == 3) || (k == 5);
      ks_req_byte  = 8'(8'h10 + k); ks_req_inv = 1'b0;
      ds_req_byte  = 8'h00;         ds_req_inv = 1'b0;
      flush        = (k == 3);
      if (k == 3) chk1("flush_busy_before", busy, 1'b1);
      if (k == 4) begin
        chk1("flush_busy_after", busy, 1'b0);
        chk1("flush_issue_cleared", sbox_in_valid, 1'b0);
      end
      if (k == 5) push_ds(8'h63, t0 + 11);
      #1;
      if (k == 3) begin
        chk1("flush_ks_ready", ks_req_ready, 1'b0);
        chk1("flush_ds_ready", ds_req_ready, 1'b0);
      end
      if (k == 5) begin
        chk1("flush_ptr_ks_ready", ks_req_ready, 1'b0);
        chk1("flush_ptr_ds_ready", ds_req_ready, 1'b1);
      end
      @(negedge clk);
    end
    flush = 1'b0; ks_req_valid = 1'b0; ds_req_valid = 1'b0;

    // Asynchronous reset in the middle of a ks stream
    for (int k = 0; k < 4; k++) begin
      ks_req_valid = 1'b1; ks_req_byte = 8'(8'h21 + k); ks_req_inv = 1'b0;
      if (k == 3) begin
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_issue_valid", sbox_in_valid, 1'b0);
        chk8("arst_sbox_in", sbox_in, 8'h00);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_ks_rsp_valid", ks_rsp_valid, 1'b0);
        chk8("arst_ks_rsp_byte", ks_rsp_byte, 8'h00);
        chk8("arst_ds_rsp_byte", ds_rsp_byte, 8'h00);
      end
      @(negedge clk);
    end
    ks_req_valid = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    ks_req_valid = 1'b1; ks_req_byte = 8'h01; ks_req_inv = 1'b0;
    ds_req_valid = 1'b1; ds_req_byte = 8'h02; ds_req_inv = 1'b0;
    push_ks(8'h7c, cyc + 6);
    #1;
    chk1("arst_first_ks_ready", ks_req_ready, 1'b1);
    chk1("arst_first_ds_ready", ds_req_ready, 1'b0);
    @(negedge clk);
    ks_req_valid = 1'b0; ds_req_valid = 1'b0;
    repeat (8) @(negedge clk);

    checks++;
    if (ks_q.size() != 0) begin
      failures++;
      $display("FAIL ks_queue_drain: got %0d pending required 0", ks_q.size());
    end
    checks++;
    if (ds_q.size() != 0) begin
      failures++;
      $display("FAIL ds_queue_drain: got %0d pending required 0", ds_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sbox_share_arbiter.md
SBOX_SHARE_ARBITER -- requirements
Module: sbox_share_arbiter

Interface
REQ-001 Parameter SBOX_LAT, default 4: fixed pipeline latency of the external shared composite-field S-box, in cycles, from sbox_in_valid to matching sbox_out; legal range 1..8.
REQ-002 clk  input  1  single clock; all flops rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  synchronous abort of all in-flight beats.
REQ-005 ks_req_valid  input  1  key-schedule requester has a byte.
REQ-006 ks_req_byte  input  8  key-schedule byte.
REQ-007 ks_req_inv  input  1  0 = forward S-box, 1 = inverse.
REQ-008 ks_req_ready  output  1  key-schedule beat accepted this cycle.
REQ-009 ds_req_valid, ds_req_byte[7:0], ds_req_inv  input  1/8/1  data-state (SubBytes) requester; same meaning as the ks_* inputs.
REQ-010 ds_req_ready  output  1  data-state beat accepted this cycle.
REQ-011 sbox_in_valid  output  1  a beat is issued to the S-box this cycle.
REQ-012 sbox_in  output  8  byte issued to the S-box.
REQ-013 sbox_inv  output  1  direction issued to the S-box.
REQ-014 sbox_out  input  8  S-box result, valid SBOX_LAT cycles after issue.
REQ-015 ks_rsp_valid, ks_rsp_byte[7:0]  output  1/8  key-schedule result strobe and data.
REQ-016 ds_rsp_valid, ds_rsp_byte[7:0]  output  1/8  data-state result strobe and data.
REQ-017 busy  output  1  at least one beat is in flight.

Function
REQ-018 At most one beat SHALL be accepted per cycle; a beat is accepted when x_req_valid and x_req_ready are both high at a rising edge.
REQ-019 ready SHALL be combinational:
- only one requester valid -> that requester is ready;
- both valid -> the requester not granted most recently is ready (round-robin);
- flush high -> neither requester is ready.
REQ-020 The last-grant pointer SHALL update only on an accepted beat.
REQ-021 An accepted beat in cycle N SHALL drive sbox_in_valid=1 in cycle N+1, with sbox_in and sbox_inv registered from the accepted requester.
REQ-022 With no beat issued, sbox_in_valid SHALL be 0; sbox_in and sbox_inv hold their previous values.
REQ-023 An owner tag shift register, SBOX_LAT+1 stages of {valid, owner}, SHALL track each issued beat.
REQ-024 The tag reaching the final stage in cycle N+1+SBOX_LAT SHALL capture sbox_out into the owner's rsp_byte register and pulse that owner's rsp_valid in cycle N+2+SBOX_LAT. End-to-end latency is SBOX_LAT+2 cycles.
REQ-025 Responses SHALL have no backpressure; each requester SHALL receive its results in its own acceptance order.
REQ-026 A non-owner rsp_valid SHALL stay 0; rsp_byte SHALL hold its last value.
REQ-027 Back-to-back acceptance every cycle SHALL be sustained with no bubbles, giving throughput of 1 byte per cycle.
REQ-028 An internal in-flight counter SHALL:
- increment on accept and decrement on response;
- on simultaneous accept and response, stay unchanged;
- never exceed SBOX_LAT+2.
busy SHALL equal (counter != 0).
REQ-029 flush SHALL clear all tag valids, the counter and sbox_in_valid at the next edge. Beats in flight SHALL produce no rsp_valid. The pointer SHALL be unchanged.

Reset
REQ-030 While rst_n is 0, the block SHALL asynchronously drive all outputs and internal state to 0:
- all *_valid outputs, busy, sbox_in, sbox_inv, rsp_bytes, tags and counter;
- last-grant pointer = ds, so ks wins the first contention.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight beats; no rsp_valid SHALL appear after rst_n rises until new beats are accepted.

Verification
REQ-032 SBOX_LAT=4, real S-box model: ks beat 0x00 fwd accepted at cycle 0 -> sbox_in_valid=1, sbox_in=0x00 at cycle 1; ks_rsp_valid=1, ks_rsp_byte=0x63 at cycle 6; ds_rsp_valid stays 0.
REQ-033 Both requesters valid every cycle (ks bytes 0x53, 0x00; ds bytes 0x63 inv, 0x01 fwd) from reset -> grants ks, ds, ks, ds. Responses: ks 0xED, ds 0x00, ks 0x63, ds 0x7C in cycles 6..9.
REQ-034 ds streams 16 consecutive bytes 0x00..0x0F -> sbox_in_valid high 16 consecutive cycles; 16 ds_rsp_valid pulses in order; busy falls the cycle after the last pulse.
REQ-035 Three beats in flight, flush pulsed 1 cycle -> no rsp_valid for those beats, busy=0 next cycle; both readies 0 during the flush cycle.
REQ-036 rst_n pulled low asynchronously mid-stream -> outputs 0 immediately without a clock edge; after release, no rsp_valid until a new accept; the first contention is granted to ks.
